// File: rtl/ex_stage.sv
// EX stage: saturating ALU, branch/call/ret resolution, registered output.
// Define EX_STAGE_MUL_EN for the iterative shift-add multiplier (alu_op 8).
module ex_stage #(
   parameter int DATA_W = 16,
   parameter int PC_W   = 16,
   parameter int RD_W   = 4,
   parameter int CALL_W = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   input  logic                flush,
   input  logic [3:0]          alu_op,
   input  logic                alu_src,
   input  logic [DATA_W-1:0]   rd_data_1,
   input  logic [DATA_W-1:0]   rd_data_2,
   input  logic [DATA_W-1:0]   sign_ext,
   input  logic [3:0]          shift,
   input  logic [DATA_W/2-1:0] load_half_imm,
   input  logic                branch,
   input  logic                call,
   input  logic                ret_wb,
   input  logic [2:0]          branch_cond,
   input  logic [CALL_W-1:0]   call_target,
   input  logic [PC_W-1:0]     pc_in,
   input  logic [PC_W-1:0]     pc_stack_pointer,
   input  logic                mem_to_reg_in,
   input  logic                reg_to_mem_in,
   input  logic                ret_future_in,
   input  logic [RD_W-1:0]     reg_rd_in,
   output logic                mem_to_reg_out,
   output logic                reg_to_mem_out,
   output logic                ret_future_out,
   output logic [RD_W-1:0]     reg_rd_out,
   output logic [DATA_W-1:0]   alu_result,
   output logic [PC_W-1:0]     pc_update,
   output logic                pc_src,
   output logic [2:0]          flags
);
   localparam int H = DATA_W / 2;
   localparam int M = DATA_W - 1;
   localparam logic [DATA_W-1:0] S_MAX = {1'b0, {M{1'b1}}};
   localparam logic [DATA_W-1:0] S_MIN = {1'b1, {M{1'b0}}};

   typedef enum logic {IDLE, MUL_BUSY} state_t;
   state_t state, state_nxt;

   logic busy, accept, is_mul, mul_last, mul_fl;
   logic ovf, flag_op, flag_en, taken, pc_src_nxt;
   logic [DATA_W-1:0] op_b, sum, dif, res, mul_res;
   logic [2:0] flags_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic [PC_W+DATA_W-1:0] se_ext;

   assign busy     = state == MUL_BUSY;
   assign in_ready = !busy && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready && !flush;
   assign op_b     = alu_src ? sign_ext : rd_data_2;
   assign sum      = rd_data_1 + op_b;
   assign dif      = rd_data_1 - op_b;

   always_comb begin
      res     = '0;
      ovf     = 1'b0;
      flag_op = 1'b0;
      case (alu_op)
         4'd0: begin
            ovf = (rd_data_1[M] == op_b[M])
               && (sum[M] != rd_data_1[M]);
            res = ovf ? (rd_data_1[M] ? S_MIN : S_MAX) : sum;
            flag_op = 1'b1;
         end
         4'd1: begin
            ovf = (rd_data_1[M] != op_b[M])
               && (dif[M] != rd_data_1[M]);
            res = ovf ? (rd_data_1[M] ? S_MIN : S_MAX) : dif;
            flag_op = 1'b1;
         end
         4'd2: begin
            res = rd_data_1 & op_b;
            flag_op = 1'b1;
         end
         4'd3: begin
            res = ~(rd_data_1 | op_b);
            flag_op = 1'b1;
         end
         4'd4: begin
            res = rd_data_1 << shift;
            flag_op = 1'b1;
         end
         4'd5: begin
            res = rd_data_1 >> shift;
            flag_op = 1'b1;
         end
         4'd6: begin
            res = $signed(rd_data_1) >>> shift;
            flag_op = 1'b1;
         end
         4'd7: res = {load_half_imm, rd_data_1[H-1:0]};
         default: ;
      endcase
   end

   assign flag_en   = (flag_op || is_mul)
                   && !branch && !call && !ret_wb;
   assign flags_nxt = {res == '0, ovf, res[M]};

   always_comb begin
      taken = 1'b0;
      case (branch_cond)
         3'd0: taken = !flags[2];
         3'd1: taken = flags[2];
         3'd2: taken = !flags[2] && !flags[0];
         3'd3: taken = flags[0];
         3'd4: taken = flags[2] || !flags[0];
         3'd5: taken = flags[0] || flags[2];
         3'd6: taken = flags[1];
         3'd7: taken = 1'b1;
      endcase
   end

   assign se_ext = {{PC_W{sign_ext[M]}}, sign_ext};

   always_comb begin
      pc_nxt     = pc_in;
      pc_src_nxt = 1'b0;
      if (ret_wb) begin
         pc_nxt     = pc_stack_pointer;
         pc_src_nxt = 1'b1;
      end else if (call) begin
         pc_nxt     = {pc_in[PC_W-1:CALL_W], call_target};
         pc_src_nxt = 1'b1;
      end else if (branch && taken) begin
         pc_nxt     = pc_in + se_ext[PC_W-1:0];
         pc_src_nxt = 1'b1;
      end
   end

`ifdef EX_STAGE_MUL_EN
   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   logic [CW-1:0] cnt;
   logic [DATA_W-1:0] acc, mcand, mplier;
   logic mul_fl_q;

   // low product bits are identical for signed and unsigned operands
   assign is_mul   = alu_op == 4'd8;
   assign mul_res  = acc + (mplier[0] ? mcand : '0);
   assign mul_last = busy && cnt == LAST;
   assign mul_fl   = mul_fl_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         mul_fl_q <= 1'b0;
      end else if (accept && is_mul) begin
         cnt      <= '0;
         acc      <= '0;
         mcand    <= rd_data_1;
         mplier   <= op_b;
         mul_fl_q <= flag_en;
      end else if (busy) begin
         cnt    <= cnt + 1'b1;
         acc    <= mul_res;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end
`else
   assign is_mul   = 1'b0;
   assign mul_res  = '0;
   assign mul_last = 1'b0;
   assign mul_fl   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept && is_mul) state_nxt = MUL_BUSY;
         MUL_BUSY: if (mul_last) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid      <= 1'b0;
         alu_result     <= '0;
         pc_update      <= '0;
         pc_src         <= 1'b0;
         flags          <= '0;
         mem_to_reg_out <= 1'b0;
         reg_to_mem_out <= 1'b0;
         ret_future_out <= 1'b0;
         reg_rd_out     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid      <= !is_mul;
         alu_result     <= res;
         pc_update      <= pc_nxt;
         pc_src         <= pc_src_nxt;
         mem_to_reg_out <= mem_to_reg_in;
         reg_to_mem_out <= reg_to_mem_in;
         ret_future_out <= ret_future_in;
         reg_rd_out     <= reg_rd_in;
         if (flag_en && !is_mul) flags <= flags_nxt;
      end else if (mul_last) begin
         out_valid  <= 1'b1;
         alu_result <= mul_res;
         if (mul_fl) flags <= {mul_res == '0, 1'b0, mul_res[M]};
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table, hand-written corner sequences,
// and a randomized handshake run against a scoreboard model.
module tb_ex_stage;
`ifdef EX_STAGE_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic in_valid, in_ready, out_valid, out_ready, flush;
   logic [3:0] alu_op, shift;
   logic alu_src, branch, call, ret_wb;
   logic [15:0] rd_data_1, rd_data_2, sign_ext;
   logic [7:0] load_half_imm;
   logic [2:0] branch_cond, flags;
   logic [11:0] call_target;
   logic [15:0] pc_in, pc_stack_pointer, alu_result, pc_update;
   logic mem_to_reg_in, reg_to_mem_in, ret_future_in;
   logic mem_to_reg_out, reg_to_mem_out, ret_future_out;
   logic [3:0] reg_rd_in, reg_rd_out;
   logic pc_src;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .flush(flush), .alu_op(alu_op), .alu_src(alu_src),
      .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
      .sign_ext(sign_ext), .shift(shift),
      .load_half_imm(load_half_imm),
      .branch(branch), .call(call), .ret_wb(ret_wb),
      .branch_cond(branch_cond), .call_target(call_target),
      .pc_in(pc_in), .pc_stack_pointer(pc_stack_pointer),
      .mem_to_reg_in(mem_to_reg_in),
      .reg_to_mem_in(reg_to_mem_in),
      .ret_future_in(ret_future_in), .reg_rd_in(reg_rd_in),
      .mem_to_reg_out(mem_to_reg_out),
      .reg_to_mem_out(reg_to_mem_out),
      .ret_future_out(ret_future_out), .reg_rd_out(reg_rd_out),
      .alu_result(alu_result), .pc_update(pc_update),
      .pc_src(pc_src), .flags(flags)
   );

   typedef struct {
      logic [3:0]  op;
      logic        src;
      logic [15:0] a, b, se;
      logic [3:0]  sh;
      logic [7:0]  lhb;
      logic        br, cl, rt;
      logic [2:0]  cond;
      logic [11:0] ct;
      logic [15:0] pc, sp;
      logic        m2r, r2m, rf;
      logic [3:0]  rd;
   } txn_t;

   typedef struct {
      logic [15:0] res, pcu;
      logic        pcs, m2r, r2m, rf;
      logic [3:0]  rd;
      logic [2:0]  fl;
   } out_t;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] a, b;
      logic [3:0]  sh;
      logic [7:0]  lhb;
      logic [15:0] res;
      logic [2:0]  fl;
   } vec_t;

   int n_pass = 0;
   int n_chk = 0;
   logic [2:0] mflags = 3'b000;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic txn_t mk(input logic [3:0] op,
                               input logic [15:0] a,
                               input logic [15:0] b);
      txn_t t;
      t = '{op: op, src: 1'b0, a: a, b: b, se: 16'h0, sh: 4'h0,
            lhb: 8'h0, br: 1'b0, cl: 1'b0, rt: 1'b0, cond: 3'd0,
            ct: 12'h0, pc: 16'h0, sp: 16'h0, m2r: 1'b0,
            r2m: 1'b0, rf: 1'b0, rd: 4'h0};
      return t;
   endfunction

   task automatic drive(input txn_t t);
      alu_op = t.op; alu_src = t.src;
      rd_data_1 = t.a; rd_data_2 = t.b; sign_ext = t.se;
      shift = t.sh; load_half_imm = t.lhb;
      branch = t.br; call = t.cl; ret_wb = t.rt;
      branch_cond = t.cond; call_target = t.ct;
      pc_in = t.pc; pc_stack_pointer = t.sp;
      mem_to_reg_in = t.m2r; reg_to_mem_in = t.r2m;
      ret_future_in = t.rf; reg_rd_in = t.rd;
   endtask

   function automatic out_t cur();
      out_t o;
      o = '{res: alu_result, pcu: pc_update, pcs: pc_src,
            m2r: mem_to_reg_out, r2m: reg_to_mem_out,
            rf: ret_future_out, rd: reg_rd_out, fl: flags};
      return o;
   endfunction

   function automatic logic [63:0] pk(input out_t o);
      return 64'({o.res, o.pcu, o.pcs, o.m2r, o.r2m,
                  o.rf, o.rd, o.fl});
   endfunction

   // reference: arithmetic on signed integers, flags as a 3-bit state
   task automatic model(input txn_t t, output out_t o);
      int sa, sb, s;
      logic [15:0] b, r;
      logic [31:0] p;
      logic upd, v, tk, z, n;
      b = t.src ? t.se : t.b;
      sa = $signed(t.a);
      sb = $signed(b);
      r = 16'h0; v = 1'b0; upd = 1'b0;
      case (t.op)
         4'd0, 4'd1: begin
            s = (t.op == 4'd0) ? sa + sb : sa - sb;
            if (s > 32767) begin r = 16'h7FFF; v = 1'b1; end
            else if (s < -32768) begin r = 16'h8000; v = 1'b1; end
            else r = s[15:0];
            upd = 1'b1;
         end
         4'd2: begin r = t.a & b; upd = 1'b1; end
         4'd3: begin r = ~(t.a | b); upd = 1'b1; end
         4'd4: begin r = t.a << t.sh; upd = 1'b1; end
         4'd5: begin r = t.a >> t.sh; upd = 1'b1; end
         4'd6: begin s = sa >>> t.sh; r = s[15:0]; upd = 1'b1; end
         4'd7: r = {t.lhb, t.a[7:0]};
         4'd8: if (MUL_EN) begin
            p = sa * sb; r = p[15:0]; upd = 1'b1;
         end
         default: ;
      endcase
      z = mflags[2]; n = mflags[0];
      case (t.cond)
         3'd0: tk = !z;
         3'd1: tk = z;
         3'd2: tk = !z && !n;
         3'd3: tk = n;
         3'd4: tk = z || !n;
         3'd5: tk = n || z;
         3'd6: tk = mflags[1];
         default: tk = 1'b1;
      endcase
      o.pcs = 1'b1;
      if (t.rt) o.pcu = t.sp;
      else if (t.cl) o.pcu = {t.pc[15:12], t.ct};
      else if (t.br && tk) o.pcu = t.pc + t.se;
      else begin o.pcu = t.pc; o.pcs = 1'b0; end
      if (upd && !t.br && !t.cl && !t.rt)
         mflags = {r == 16'h0, v, r[15]};
      o.res = r; o.fl = mflags;
      o.m2r = t.m2r; o.r2m = t.r2m; o.rf = t.rf; o.rd = t.rd;
   endtask

   task automatic do_op(input txn_t t, output out_t o);
      int i;
      @(negedge clk);
      drive(t);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      i = 0;
      while (!in_ready && i < 40) begin
         @(negedge clk); #1; i++;
      end
      if (!in_ready) chk("accept_timeout", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      i = 0;
      while (!out_valid && i < 40) begin
         @(negedge clk); i++;
      end
      if (!out_valid) chk("result_timeout", out_valid, 1);
      o = cur();
      @(posedge clk); #1;
   endtask

   vec_t tbl[15];
   out_t o, e;
   txn_t t;
   out_t q[$];

   initial begin
      int busy_cnt, seen;
      tbl[0]  = '{4'd0, 16'h7FFF, 16'h0001, 4'd0, 8'h00, 16'h7FFF, 3'b010};
      tbl[1]  = '{4'd0, 16'h8000, 16'hFFFF, 4'd0, 8'h00, 16'h8000, 3'b011};
      tbl[2]  = '{4'd1, 16'h0005, 16'h0005, 4'd0, 8'h00, 16'h0000, 3'b100};
      tbl[3]  = '{4'd1, 16'h8000, 16'h0001, 4'd0, 8'h00, 16'h8000, 3'b011};
      tbl[4]  = '{4'd1, 16'h7FFF, 16'hFFFF, 4'd0, 8'h00, 16'h7FFF, 3'b010};
      tbl[5]  = '{4'd2, 16'hF0F0, 16'h0FF0, 4'd0, 8'h00, 16'h00F0, 3'b000};
      tbl[6]  = '{4'd3, 16'h0000, 16'h0000, 4'd0, 8'h00, 16'hFFFF, 3'b001};
      tbl[7]  = '{4'd4, 16'h0001, 16'h0000, 4'd15, 8'h00, 16'h8000, 3'b001};
      tbl[8]  = '{4'd5, 16'h8000, 16'h0000, 4'd15, 8'h00, 16'h0001, 3'b000};
      tbl[9]  = '{4'd6, 16'h8000, 16'h0000, 4'd4, 8'h00, 16'hF800, 3'b001};
      tbl[10] = '{4'd7, 16'h1234, 16'h0000, 4'd0, 8'hAB, 16'hAB34, 3'b001};
      tbl[11] = '{4'd9, 16'h1234, 16'h1111, 4'd0, 8'h00, 16'h0000, 3'b001};
      tbl[12] = '{4'd15, 16'hFFFF, 16'hFFFF, 4'd0, 8'h00, 16'h0000, 3'b001};
      tbl[13] = '{4'd0, 16'h0003, 16'h0004, 4'd0, 8'h00, 16'h0007, 3'b000};
      tbl[14] = '{4'd6, 16'h7FFF, 16'h0000, 4'd0, 8'h00, 16'h7FFF, 3'b000};

      t = mk(4'd0, 16'h0, 16'h0);
      t.m2r = 1'b1; t.r2m = 1'b1; t.rf = 1'b1; t.rd = 4'hF;
      t.pc = 16'hFFFF;
      drive(t);
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
      #12;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_outputs", pk(cur()), 64'h0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("reset_in_ready", in_ready, 1);

      for (int i = 0; i < 15; i++) begin
         t = mk(tbl[i].op, tbl[i].a, tbl[i].b);
         t.sh = tbl[i].sh; t.lhb = tbl[i].lhb;
         t.rd = 4'(i); t.m2r = i[0]; t.pc = 16'(i * 3);
         do_op(t, o);
         chk($sformatf("vec%0d_res", i), o.res, tbl[i].res);
         chk($sformatf("vec%0d_flags", i), o.fl, tbl[i].fl);
         chk($sformatf("vec%0d_side", i),
             {o.rd, o.m2r, o.pcu, o.pcs},
             {4'(i), i[0], 16'(i * 3), 1'b0});
      end

      do_op(mk(4'd1, 16'd5, 16'd5), o);
      chk("sub_zero_flags", o.fl, 3'b100);
      t = mk(4'd0, 16'd1, 16'd1);
      t.br = 1'b1; t.cond = 3'd1; t.pc = 16'h0100; t.se = 16'h0010;
      do_op(t, o);
      chk("beq_taken", {o.pcu, o.pcs}, {16'h0110, 1'b1});
      chk("branch_keeps_flags", o.fl, 3'b100);
      t.cond = 3'd0;
      do_op(t, o);
      chk("bne_not_taken", {o.pcu, o.pcs}, {16'h0100, 1'b0});
      t.cond = 3'd7; t.se = 16'hFFF0;
      do_op(t, o);
      chk("always_back", {o.pcu, o.pcs}, {16'h00F0, 1'b1});
      t = mk(4'd0, 16'd1, 16'd1);
      t.cl = 1'b1; t.pc = 16'hA234; t.ct = 12'h056;
      do_op(t, o);
      chk("call_target", {o.pcu, o.pcs}, {16'hA056, 1'b1});
      t.rt = 1'b1; t.sp = 16'h4321;
      do_op(t, o);
      chk("ret_over_call", {o.pcu, o.pcs}, {16'h4321, 1'b1});
      chk("call_keeps_flags", o.fl, 3'b100);

      do_op(mk(4'd8, 16'd3, 16'd7), o);
`ifdef EX_STAGE_MUL_EN
      chk("mul_result", {o.res, o.fl}, {16'h0015, 3'b000});
      @(negedge clk);
      drive(mk(4'd8, 16'd3, 16'd7));
      in_valid = 1'b1;
      #1 chk("mul_accept", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      busy_cnt = 0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (!in_ready && !out_valid) busy_cnt++;
      end
      chk("mul_busy_cycles", busy_cnt, 16);
      @(negedge clk);
      chk("mul_cycle17", {out_valid, alu_result}, {1'b1, 16'h0015});
      @(posedge clk); #1;
      @(negedge clk);
      drive(mk(4'd8, 16'h0102, 16'h0304));
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1 chk("mul_reset", {out_valid, in_ready, flags}, {1'b0, 1'b1, 3'b000});
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("mul_reset_ready", in_ready, 1);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("mul_abandoned", seen, 0);
`else
      chk("op8_undefined", {o.res, o.fl}, {16'h0000, 3'b100});
`endif

      @(negedge clk);
      drive(mk(4'd0, 16'd1, 16'd2));
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      drive(mk(4'd0, 16'd10, 16'd20));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_hold", {out_valid, alu_result, in_ready},
             {1'b1, 16'd3, 1'b0});
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1 chk("stall_release", {in_ready, alu_result}, {1'b1, 16'd3});
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("stall_next", {out_valid, alu_result}, {1'b1, 16'd30});
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_no_dup", out_valid, 0);

      @(negedge clk);
      drive(mk(4'd0, 16'h8000, 16'h8000));
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      drive(mk(4'd1, 16'd5, 16'd5));
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_kill", {out_valid, flags}, {1'b0, 3'b011});
      @(negedge clk);
      chk("flush_no_accept", out_valid, 0);

      @(negedge clk);
      rst_n = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      mflags = 3'b000;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         t = mk(4'($urandom_range(0, 15)), 16'($urandom),
                16'($urandom));
         t.src = 1'($urandom); t.se = 16'($urandom);
         t.sh = 4'($urandom); t.lhb = 8'($urandom);
         t.br = ($urandom_range(0, 3) == 0);
         t.cl = ($urandom_range(0, 7) == 0);
         t.rt = ($urandom_range(0, 7) == 0);
         t.cond = 3'($urandom); t.ct = 12'($urandom);
         t.pc = 16'($urandom); t.sp = 16'($urandom);
         t.m2r = 1'($urandom); t.r2m = 1'($urandom);
         t.rf = 1'($urandom); t.rd = 4'($urandom);
         drive(t);
         in_valid = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         #1;
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("rand_spurious", out_valid, 0);
            else begin
               e = q.pop_front();
               chk("rand_out", pk(cur()), pk(e));
            end
         end
         if (in_valid && in_ready) begin
            model(t, e);
            q.push_back(e);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 60 && q.size() != 0; c++) begin
         @(negedge clk);
         if (out_valid) begin
            e = q.pop_front();
            chk("drain_out", pk(cur()), pk(e));
         end
      end
      chk("drain_empty", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
Parameters:
REQ-001 SHALL provide DATA_W, default 16, datapath/ALU width (min 8).
REQ-002 SHALL provide PC_W, default 16, program-counter width.
REQ-003 SHALL provide RD_W, default 4, register-file destination index width.
REQ-004 SHALL provide CALL_W, default 12, call-target immediate width (CALL_W < PC_W).
Ports:
REQ-005 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have in_valid  input  1, in_ready  output  1  upstream handshake.
REQ-008 SHALL have out_valid  output  1, out_ready  input  1  downstream handshake.
REQ-009 SHALL have flush  input  1  kill in-flight/held operation.
REQ-010 SHALL have alu_op  input  4  (0 ADD,1 SUB,2 AND,3 NOR,4 SLL,5 SRL,6 SRA,7 LHB,8 MUL).
REQ-011 SHALL have alu_src  input  1  operand-2 select (0 rd_data_2, 1 sign_ext).
REQ-012 SHALL have rd_data_1, rd_data_2, sign_ext  input  DATA_W each; shift  input  4; load_half_imm  input  DATA_W/2.
REQ-013 SHALL have branch, call, ret_wb  input  1 each; branch_cond  input  3; call_target  input  CALL_W; pc_in, pc_stack_pointer  input  PC_W.
REQ-014 SHALL have mem_to_reg_in, reg_to_mem_in, ret_future_in  input  1; reg_rd_in  input  RD_W; each SHALL have a registered *_out counterpart.
REQ-015 SHALL have alu_result  output  DATA_W; pc_update  output  PC_W; pc_src  output  1; flags  output  3 {Z,V,N}.

Function
REQ-016 Transfer accepted when in_valid && in_ready; in_ready = !busy && (!out_valid || out_ready).
REQ-017 Single-cycle ops: result and sideband registered on acceptance edge; out_valid asserts next cycle (latency 1).
REQ-018 Output register SHALL hold all outputs stable while out_valid && !out_ready.
REQ-019 ADD/SUB SHALL saturate to signed max/min on overflow; V=1 only then, else V=0.
REQ-020 LHB result = {load_half_imm, rd_data_1[DATA_W/2-1:0]}; shifts use shift[3:0], SRA sign-fills.
REQ-021 Z = (result==0), N = result MSB; flag register updates only on accepted ADD/SUB/AND/NOR/SLL/SRL/SRA/MUL with branch=call=ret_wb=0; AND/NOR/shifts/MUL clear V.
REQ-022 Undefined alu_op (9-15, or 8 without macro): result 0, flags unchanged.
REQ-023 Branch conditions on current flag register: 0 NE(!Z),1 EQ(Z),2 GT(!Z&&!N),3 LT(N),4 GE(Z||!N),5 LE(N||Z),6 OV(V),7 always.
REQ-024 Priority ret_wb > call > branch: ret -> pc_update=pc_stack_pointer; call -> {pc_in[PC_W-1:CALL_W], call_target}; taken branch -> pc_in + sign_ext (truncated to PC_W); pc_src=1 for these, else pc_src=0, pc_update=pc_in.
REQ-025 State machine IDLE, MUL_BUSY; busy=1 in MUL_BUSY; IDLE->MUL_BUSY on accepted MUL; MUL_BUSY->IDLE after DATA_W iterations with output register loaded.
REQ-026 flush SHALL clear out_valid and return to IDLE next edge, flags unchanged; flush with simultaneous in_valid accepts nothing.

Reset
REQ-027 rst_n low SHALL immediately clear out_valid, pc_src, flags, all *_out, alu_result, pc_update to 0, state to IDLE.
REQ-028 Reset mid-multiply SHALL abandon it; in_ready=1 on first cycle after release.

Configuration
REQ-029 Macro EX_STAGE_MUL_EN: defined -> alu_op 8 is iterative shift-add signed multiply, low DATA_W bits, DATA_W cycles in MUL_BUSY, out_valid DATA_W+1 cycles after acceptance; undefined -> no multiplier, state stays IDLE, op 8 per REQ-022.

Verification
REQ-030 ADD 0x7FFF+0x0001 -> alu_result 0x7FFF, flags V=1,N=0,Z=0 next cycle.
REQ-031 SUB 5-5 then branch cond 1, pc_in 0x0100, sign_ext 0x0010 -> pc_update 0x0110, pc_src=1.
REQ-032 call, pc_in 0xA234, call_target 0x056 -> pc_update 0xA056; ret_wb with call -> pc_update=pc_stack_pointer.
REQ-033 out_ready held 0 for 3 cycles -> outputs stable, in_ready=0, no drop/duplicate after release.
REQ-034 MUL_EN: MUL 3*7 -> in_ready=0 16 cycles, alu_result 0x0015 at cycle 17; rst_n low at cycle 5 -> out_valid=0, IDLE.
REQ-035 flush with out_valid=1 -> out_valid=0 next cycle, flags unchanged.
